// File: rtl/reg_mm_master.sv
// Avalon-MM host for register-bank slaves: takes one read/write command at a
// time, runs it on the bus honouring waitrequest, and returns a one-cycle
// response carrying read data and a timeout flag. Every output is a flop.
module reg_mm_master #(
  parameter int ADDR_W            = 32,
  parameter int DATA_W            = 32,
  parameter int USE_READDATAVALID = 1,
  parameter int READ_LATENCY      = 1,
  parameter int TIMEOUT_CYCLES    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  // One counter serves both the timeout and the fixed read latency, since both
  // restart on state entry; it is wide enough for either limit.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 16);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic                avm_read_q, avm_read_d;
  logic                avm_write_q, avm_write_d;
  logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
  logic                timeout_hit;
  logic                rd_done;
  logic                in_wait_state;

  assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_wait_state = (state_q == ST_WR) || (state_q == ST_RD_REQ) ||
                         (state_q == ST_RD_WAIT);

  // Read completion in RD_WAIT: readdatavalid, or the fixed latency expiring.
  always_comb begin
    rd_done = 1'b0;
    if (USE_READDATAVALID != 0) begin
      rd_done = avm_readdatavalid;
    end else begin
      rd_done = (cnt_q == CNT_W'(READ_LATENCY - 1));
    end
  end

  // Next-state and registered-output computation; completion beats timeout.
  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    rsp_rdata_d     = '0;
    rsp_timeout_d   = 1'b0;
    cnt_d           = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          avm_address_d   = cmd_addr;
          avm_writedata_d = cmd_wdata;
          state_d         = cmd_write ? ST_WR : ST_RD_REQ;
        end
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          // Data arriving with the acceptance skips RD_WAIT entirely.
          if ((USE_READDATAVALID != 0) && avm_readdatavalid) begin
            rsp_rdata_d = avm_readdata;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (rd_done) begin
          rsp_rdata_d = avm_readdata;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait_state) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    avm_write_d = (state_d == ST_WR);
    avm_read_d  = (state_d == ST_RD_REQ);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_reg_mm_master.sv
// Directed bench for reg_mm_master: instance A uses readdatavalid with an
// 8-cycle timeout, instance B uses a fixed read latency of 2.
module tb_reg_mm_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A signals
  logic        a_cmd_valid = 0, a_cmd_write = 0, a_cmd_ready;
  logic [31:0] a_cmd_addr = 0, a_cmd_wdata = 0;
  logic        a_rsp_valid, a_rsp_timeout;
  logic [31:0] a_rsp_rdata, a_avm_address, a_avm_writedata;
  logic        a_avm_read, a_avm_write;
  logic [31:0] a_avm_readdata = 0;
  logic        a_avm_readdatavalid = 0, a_avm_waitrequest = 0;

  // Instance B signals
  logic        b_cmd_valid = 0, b_cmd_write = 0, b_cmd_ready;
  logic [31:0] b_cmd_addr = 0, b_cmd_wdata = 0;
  logic        b_rsp_valid, b_rsp_timeout;
  logic [31:0] b_rsp_rdata, b_avm_address, b_avm_writedata;
  logic        b_avm_read, b_avm_write;
  logic [31:0] b_avm_readdata = 0;
  logic        b_avm_readdatavalid = 0, b_avm_waitrequest = 0;

  reg_mm_master #(
    .ADDR_W(32), .DATA_W(32), .USE_READDATAVALID(1),
    .READ_LATENCY(1), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_timeout(a_rsp_timeout),
    .avm_address(a_avm_address), .avm_read(a_avm_read), .avm_write(a_avm_write),
    .avm_writedata(a_avm_writedata), .avm_readdata(a_avm_readdata),
    .avm_readdatavalid(a_avm_readdatavalid), .avm_waitrequest(a_avm_waitrequest)
  );

  reg_mm_master #(
    .ADDR_W(32), .DATA_W(32), .USE_READDATAVALID(0),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_timeout(b_rsp_timeout),
    .avm_address(b_avm_address), .avm_read(b_avm_read), .avm_write(b_avm_write),
    .avm_writedata(b_avm_writedata), .avm_readdata(b_avm_readdata),
    .avm_readdatavalid(b_avm_readdatavalid), .avm_waitrequest(b_avm_waitrequest)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst cmd_ready", a_cmd_ready, 1);
    check("rst avm_read", a_avm_read, 0);
    check("rst avm_write", a_avm_write, 0);
    check("rst rsp_valid", a_rsp_valid, 0);
    check("rst avm_address", a_avm_address, 0);
    rst = 1'b0;
    tick();

    // Write, no wait states
    a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 32'h2; a_cmd_wdata = 32'hDEADBEEF;
    tick();
    a_cmd_valid = 0;
    check("wr avm_write", a_avm_write, 1);
    check("wr avm_address", a_avm_address, 32'h2);
    check("wr avm_writedata", a_avm_writedata, 32'hDEADBEEF);
    check("wr cmd_ready low", a_cmd_ready, 0);
    tick();
    check("wr avm_write 1 cycle", a_avm_write, 0);
    check("wr rsp_valid", a_rsp_valid, 1);
    check("wr rsp_timeout", a_rsp_timeout, 0);
    check("wr rsp_rdata", a_rsp_rdata, 0);
    check("wr cmd_ready in RESP", a_cmd_ready, 0);
    tick();
    check("wr rsp pulse ends", a_rsp_valid, 0);
    check("wr cmd_ready back", a_cmd_ready, 1);

    // Read with readdatavalid one cycle after acceptance
    a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 32'h2;
    tick();
    a_cmd_valid = 0;
    check("rd avm_read", a_avm_read, 1);
    check("rd avm_address", a_avm_address, 32'h2);
    check("rd avm_write low", a_avm_write, 0);
    tick();
    check("rd avm_read dropped", a_avm_read, 0);
    check("rd cmd_ready low", a_cmd_ready, 0);
    check("rd no early rsp", a_rsp_valid, 0);
    a_avm_readdata = 32'hDEADBEEF; a_avm_readdatavalid = 1;
    tick();
    a_avm_readdatavalid = 0; a_avm_readdata = 0;
    check("rd rsp_valid", a_rsp_valid, 1);
    check("rd rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
    check("rd cmd_ready in RESP", a_cmd_ready, 0);
    tick();
    check("rd cmd_ready back", a_cmd_ready, 1);
    check("rd rsp_rdata cleared", a_rsp_rdata, 0);

    // Stray readdatavalid in IDLE is ignored
    a_avm_readdatavalid = 1; a_avm_readdata = 32'h55;
    tick();
    a_avm_readdatavalid = 0;
    check("stray rdv rsp_valid", a_rsp_valid, 0);
    check("stray rdv cmd_ready", a_cmd_ready, 1);

    // Write with 3 wait states
    a_avm_waitrequest = 1;
    a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 32'h0; a_cmd_wdata = 32'h12345678;
    tick();
    a_cmd_valid = 0; a_cmd_addr = 32'hFF; a_cmd_wdata = 32'hFF;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws avm_write c%0d", i), a_avm_write, 1);
      check($sformatf("ws address c%0d", i), a_avm_address, 32'h0);
      check($sformatf("ws wdata c%0d", i), a_avm_writedata, 32'h12345678);
      if (i == 3) a_avm_waitrequest = 0;
      tick();
    end
    check("ws avm_write dropped", a_avm_write, 0);
    check("ws rsp_valid", a_rsp_valid, 1);
    check("ws rsp_timeout", a_rsp_timeout, 0);
    tick();
    check("ws single response", a_rsp_valid, 0);

    // Read accepted with readdatavalid in the same cycle skips RD_WAIT
    a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 32'h7;
    tick();
    a_cmd_valid = 0;
    a_avm_readdatavalid = 1; a_avm_readdata = 32'hA5A5A5A5;
    tick();
    a_avm_readdatavalid = 0; a_avm_readdata = 0;
    check("skip rsp_valid", a_rsp_valid, 1);
    check("skip rsp_rdata", a_rsp_rdata, 32'hA5A5A5A5);
    tick();

    // Timeout: waitrequest stuck high on a read
    a_avm_waitrequest = 1;
    a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 32'h4;
    tick();
    a_cmd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to avm_read c%0d", i), a_avm_read, 1);
      tick();
    end
    check("to avm_read dropped", a_avm_read, 0);
    check("to rsp_valid", a_rsp_valid, 1);
    check("to rsp_timeout", a_rsp_timeout, 1);
    check("to rsp_rdata", a_rsp_rdata, 0);
    a_avm_waitrequest = 0;
    tick();
    check("to cmd_ready back", a_cmd_ready, 1);
    check("to rsp_timeout clear", a_rsp_timeout, 0);
    a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 32'h9; a_cmd_wdata = 32'h99;
    tick();
    a_cmd_valid = 0;
    check("post-to avm_write", a_avm_write, 1);
    tick();
    check("post-to rsp_valid", a_rsp_valid, 1);
    check("post-to rsp_timeout", a_rsp_timeout, 0);
    tick();

    // Reset asserted while waiting for read data
    a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 32'h3;
    tick();
    a_cmd_valid = 0;
    tick();
    check("rstmid in RD_WAIT cmd_ready", a_cmd_ready, 0);
    rst = 1'b1;
    #1;
    check("rstmid avm_read", a_avm_read, 0);
    check("rstmid rsp_valid", a_rsp_valid, 0);
    check("rstmid cmd_ready", a_cmd_ready, 1);
    tick();
    rst = 1'b0;
    a_avm_readdatavalid = 1; a_avm_readdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmid no rsp c%0d", i), a_rsp_valid, 0);
    end
    a_avm_readdatavalid = 0;

    // Fixed latency 2 on instance B; readdata shows which cycle was captured
    b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = 32'h0;
    tick();
    b_cmd_valid = 0;
    check("fl avm_read", b_avm_read, 1);
    b_avm_readdata = 32'd8;
    tick();
    check("fl avm_read dropped", b_avm_read, 0);
    b_avm_readdata = 32'd9;
    tick();
    check("fl no rsp after 1", b_rsp_valid, 0);
    b_avm_readdata = 32'd10;
    tick();
    b_avm_readdata = 32'd11;
    check("fl rsp_valid", b_rsp_valid, 1);
    check("fl rsp_rdata", b_rsp_rdata, 32'd10);
    check("fl rsp_timeout", b_rsp_timeout, 0);
    tick();
    check("fl cmd_ready back", b_cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_mm_master.md
Name: reg_mm_master

Overview:
- Avalon-MM host that drives register-bank slaves such as the loopback registers controller.
- Accepts single read/write commands over a valid/ready command port and runs one Avalon transaction at a time, honouring waitrequest.
- Captures read data using either readdatavalid or a fixed read latency, then returns a one-cycle response carrying data and a timeout flag.
- Used by the loopback control path and by benches in place of hand-driven bus stimulus.

Parameters:
- ADDR_W, 32, Avalon address width.
- DATA_W, 32, Avalon data width.
- USE_READDATAVALID, 1, 1: read completes on readdatavalid; 0: read completes a fixed READ_LATENCY cycles after the read is accepted.
- READ_LATENCY, 1, fixed read latency in cycles (1..15); used only when USE_READDATAVALID=0.
- TIMEOUT_CYCLES, 256, cycles a transaction may stay in one wait state before it is aborted (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transaction aborted by timeout.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_readdatavalid  in  1  Avalon read-data valid.
- avm_waitrequest  in  1  Avalon stall.

Behaviour:
- Reset (async assert, any state): state=IDLE; cmd_ready=1; all other outputs 0; timeout counter 0. An in-flight transaction is dropped and produces no response.
- All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On a handshake: latch addr and wdata onto avm_address/avm_writedata, clear cmd_ready, set avm_write or avm_read, then go to WR or RD_REQ.
- WR: hold avm_write and address/data stable.
  - Sampling avm_waitrequest=0 completes the transfer: deassert avm_write, go to RESP with rsp_timeout=0.
- RD_REQ: hold avm_read.
  - Sampling waitrequest=0 accepts the read: deassert avm_read, go to RD_WAIT.
- RD_WAIT:
  - USE_READDATAVALID=1: on readdatavalid=1, capture avm_readdata into rsp_rdata and go to RESP.
  - USE_READDATAVALID=0: count READ_LATENCY cycles from acceptance, then capture readdata the cycle the count expires.
  - If readdatavalid arrives in the same cycle the read is accepted, capture it immediately; RD_WAIT is skipped.
- RESP: rsp_valid=1 for exactly one cycle. Next cycle: state=IDLE, cmd_ready=1.
  - Minimum cycle cost: a write costs 3 cycles from handshake to cmd_ready high again with no wait states; a latency-1 read costs 4.
- Timeout:
  - The counter clears on every state entry and increments every cycle spent in WR, RD_REQ or RD_WAIT.
  - When it reaches TIMEOUT_CYCLES-1: deassert avm_read/avm_write, set rsp_timeout=1 and rsp_rdata=0, go to RESP.
  - If completion and the timeout fire in the same cycle, completion wins.
- Stray readdatavalid outside RD_WAIT is ignored.
- avm_address and avm_writedata keep their last values in IDLE; avm_read and avm_write are never both 1.
- No command pipelining: at most one outstanding transaction.

Test Plan:
- Write, no wait states: cmd write addr=0x2 data=0xDEADBEEF -> avm_write high exactly 1 cycle with addr 0x2 and data 0xDEADBEEF; rsp_valid pulse with rsp_timeout=0 and rsp_rdata=0.
- Read with readdatavalid: read addr=0x2; slave returns 0xDEADBEEF with readdatavalid 1 cycle after acceptance -> rsp_rdata=0xDEADBEEF; cmd_ready low from handshake until the cycle after rsp_valid.
- Wait states: waitrequest held 3 cycles on a write to 0x0 -> avm_write stays high 4 cycles with address/data stable; one response.
- Fixed latency: USE_READDATAVALID=0, READ_LATENCY=2, read addr 0x0 while counter=10 -> rsp_rdata=10, captured exactly 2 cycles after acceptance.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops after 8 cycles; rsp_valid with rsp_timeout=1 and rsp_rdata=0; next command accepted normally.
- Reset mid-read: assert rst in RD_WAIT -> avm_read=0, rsp_valid=0, cmd_ready=1 immediately; no response emitted after release.
